// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, reset divisor and FSM states.
package uart_tx_mmio_pkg;

    // Register offsets, decoded from a[3:2]
    localparam logic [1:0] UART_REG_TXDATA = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_DIV    = 2'd2;
    localparam logic [1:0] UART_REG_CTRL   = 2'd3;

    // STATUS bit indices
    localparam int UART_STAT_FULL      = 0;
    localparam int UART_STAT_EMPTY     = 1;
    localparam int UART_STAT_BUSY      = 2;
    localparam int UART_STAT_OVERFLOW  = 3;
    localparam int UART_STAT_COUNT_LSB = 8;

    // 100 MHz / 115200 baud
    localparam int UART_DEFAULT_DIV = 868;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_fifo_sync.sv
// Synchronous first-word-fall-through FIFO. dout always shows the oldest
// entry so a consumer can pop and use the data in the same cycle.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents are only meaningful below count
    // NOTE: the data array has no reset -- pointers and count define validity, so resetting it only costs routing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged
    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, baud counter,
// shifter and framing FSM. The bus read-data port is named rdata because
// "do" is a reserved word in SystemVerilog.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] di,
    input  logic [3:0]  m,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_merged;
    logic [DIV_WIDTH-1:0] div_wdata;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [7:0]           shifter;
    logic [2:0]           bit_idx;
    logic                 irq_en;
    logic                 overflow;
    logic                 bit_done;
    logic [1:0]           reg_addr;
    logic                 wr;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 busy;
    logic                 unused_bits;

    assign reg_addr    = a[3:2];
    assign wr          = sel & we;
    assign fifo_push   = wr && (reg_addr == UART_REG_TXDATA) && m[0];
    assign bit_done    = (baud_cnt == '0);
    assign busy        = (state != ST_IDLE);
    assign unused_bits = ^{a, di};

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (di[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Byte-masked merge of a DIV write; a zero divisor is forced to 1
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        div_merged = div_q;
        for (int b = 0; b < DIV_WIDTH; b++) begin
            if (m[b[4:3]]) div_merged[b] = di[b];
        end
        div_wdata = (div_merged == '0) ? DIV_WIDTH'(1) : div_merged;
    end

    // Control/status registers and the registered interrupt line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= DIV_WIDTH'(DEFAULT_DIV);
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr && reg_addr == UART_REG_DIV) div_q <= div_wdata;
            if (wr && reg_addr == UART_REG_CTRL && m[0]) irq_en <= di[0];
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (wr && reg_addr == UART_REG_STATUS && m[0] && di[UART_STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            irq <= irq_en & fifo_empty & ~busy;
        end
    end

    // Register read mux; reads have no side effects
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_addr)
                UART_REG_STATUS: begin
                    rdata[UART_STAT_FULL]     = fifo_full;
                    rdata[UART_STAT_EMPTY]    = fifo_empty;
                    rdata[UART_STAT_BUSY]     = busy;
                    rdata[UART_STAT_OVERFLOW] = overflow;
                    rdata[UART_STAT_COUNT_LSB +: 8] = 8'(fifo_count);
                end
                UART_REG_DIV:  rdata[DIV_WIDTH-1:0] = div_q;
                UART_REG_CTRL: rdata[0] = irq_en;
                default:       rdata = '0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and FIFO pop decision; STOP chains straight into START when data waits
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: if (bit_done) state_next = ST_DATA;
            ST_DATA:  if (bit_done && bit_idx == 3'd7) state_next = ST_STOP;
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Baud counter, shifter and txd; DIV is sampled only at reload so a mid-bit write waits for the boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txd      <= 1'b1;
            baud_cnt <= '0;
            shifter  <= '0;
            bit_idx  <= '0;
        end else if (state == ST_IDLE) begin
            if (fifo_pop) begin
                shifter  <= fifo_dout;
                txd      <= 1'b0;
                baud_cnt <= div_q - 1'b1;
            end
        end else if (bit_done) begin
            baud_cnt <= div_q - 1'b1;
            case (state)
                ST_START: begin
                    txd     <= shifter[0];
                    shifter <= shifter >> 1;
                    bit_idx <= '0;
                end
                ST_DATA: begin
                    if (bit_idx == 3'd7) begin
                        txd <= 1'b1;
                    end else begin
                        txd     <= shifter[0];
                        shifter <= shifter >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (fifo_pop) begin
                        shifter <= fifo_dout;
                        txd     <= 1'b0;
                    end
                end
                default: txd <= 1'b1;
            endcase
        end else begin
            baud_cnt <= baud_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio: register access, 8N1 framing,
// back-to-back frames, FIFO overflow, interrupt timing and mid-frame reset.
module tb_uart_tx_mmio;
    import uart_tx_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] di = '0;
    logic [3:0]  m = '0;
    logic [31:0] rdata;
    logic        txd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_tx_mmio dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .a     (a),
        .di    (di),
        .m     (m),
        .rdata (rdata),
        .txd   (txd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    // Expected txd level for bit slot j (0 start, 1..8 data LSB first, 9 stop)
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        logic [7:0] v;
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        v = b >> (j - 1);
        return v[0];
    endfunction

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] mk);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; a = {28'd0, r, 2'b00}; di = d; m = mk;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; a = '0; di = '0; m = '0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; a = {28'd0, r, 2'b00};
        #1;
        d = rdata;
        sel = 1'b0; a = '0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL reset_status got %h want 00000002", v); end
        bus_read(UART_REG_DIV, v);
        checks++;
        if (v !== 32'd868) begin errors++; $display("FAIL reset_div got %0d want 868", v); end
        bus_read(UART_REG_CTRL, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", v); end
        bus_read(UART_REG_TXDATA, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL txdata_read got %h want 0", v); end
    endtask

    task automatic test_single_frame;
        logic [31:0] v;
        logic        want;
        bus_write(UART_REG_DIV, 32'd4, 4'hF);
        bus_write(UART_REG_TXDATA, 32'h55, 4'h1);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL frame55_latency got %b want 1 before next edge", txd); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            want = frame_bit(8'h55, k / 4);
            checks++;
            if (txd !== want) begin errors++; $display("FAIL frame55 cycle %0d got %b want %b", k, txd, want); end
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL frame55_idle got %b want 1", txd); end
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL frame55_status got %h want 00000002", v); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  bytes [3];
        logic [31:0] v;
        logic [31:0] sv;
        logic        want;
        logic        found;
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        bus_write(UART_REG_DIV, 32'd2, 4'hF);
        fork
            begin
                for (int i = 0; i < 3; i++) bus_write(UART_REG_TXDATA, {24'd0, bytes[i]}, 4'h1);
            end
            begin
                found = 1'b0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (txd === 1'b0) begin found = 1'b1; break; end
                end
                checks++;
                if (!found) begin
                    errors++; $display("FAIL b2b_start got no start bit want start within 20 cycles");
                end else begin
                    for (int k = 0; k < 60; k++) begin
                        if (k > 0) @(negedge clk);
                        want = frame_bit(bytes[k / 20], (k % 20) / 2);
                        checks++;
                        if (txd !== want) begin errors++; $display("FAIL b2b cycle %0d got %b want %b", k, txd, want); end
                        if (k == 50) begin
                            bus_read(UART_REG_STATUS, sv);
                            checks++;
                            if (sv[2:1] !== 2'b11) begin errors++; $display("FAIL b2b_empty_busy got %b want 11", sv[2:1]); end
                        end
                    end
                end
            end
        join
        @(negedge clk);
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL b2b_final_status got %h want 00000002", v); end
    endtask

    task automatic test_overflow;
        logic [31:0] v;
        bus_write(UART_REG_DIV, 32'd1000, 4'hF);
        for (int i = 0; i < 9; i++) bus_write(UART_REG_TXDATA, 32'h10 + i, 4'h1);
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h0805) begin errors++; $display("FAIL fifo_full got %h want 00000805", v); end
        bus_write(UART_REG_TXDATA, 32'hEE, 4'h1);
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h080D) begin errors++; $display("FAIL overflow_set got %h want 0000080d", v); end
        bus_write(UART_REG_STATUS, 32'h8, 4'h2);
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h080D) begin errors++; $display("FAIL w1c_needs_m0 got %h want 0000080d", v); end
        bus_write(UART_REG_STATUS, 32'h8, 4'h1);
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h0805) begin errors++; $display("FAIL overflow_clear got %h want 00000805", v); end
        bus_write(UART_REG_DIV, 32'd1, 4'hF);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            bus_read(UART_REG_STATUS, v);
            if (v == 32'h2) break;
        end
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL drain got %h want 00000002", v); end
    endtask

    task automatic test_div_regs;
        logic [31:0] v;
        bus_write(UART_REG_DIV, 32'd0, 4'hF);
        bus_read(UART_REG_DIV, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL div_zero got %h want 1", v); end
        bus_write(UART_REG_DIV, 32'h0A0B, 4'hF);
        bus_write(UART_REG_DIV, 32'h1234, 4'h1);
        bus_read(UART_REG_DIV, v);
        checks++;
        if (v !== 32'h0A34) begin errors++; $display("FAIL div_mask got %h want 00000a34", v); end
        @(negedge clk);
        sel = 1'b0; we = 1'b1; a = {28'd0, UART_REG_DIV, 2'b00}; di = 32'hFFFF; m = 4'hF;
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_unselected got %h want 0", rdata); end
        @(negedge clk);
        we = 1'b0; a = '0; di = '0; m = '0;
        bus_read(UART_REG_DIV, v);
        checks++;
        if (v !== 32'h0A34) begin errors++; $display("FAIL we_without_sel got %h want 00000a34", v); end
        bus_write(UART_REG_CTRL, 32'hFFFF_FFFF, 4'hF);
        bus_read(UART_REG_CTRL, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL ctrl_read got %h want 1", v); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle got %b want 1", irq); end
        bus_write(UART_REG_CTRL, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable got %b want 0", irq); end
    endtask

    task automatic test_irq;
        bus_write(UART_REG_DIV, 32'd2, 4'hF);
        bus_write(UART_REG_TXDATA, 32'h3C, 4'h1);
        bus_write(UART_REG_CTRL, 32'h1, 4'h1);
        checks++;
        if (txd !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_frame_start got txd=%b irq=%b want txd=0 irq=0", txd, irq);
        end
        for (int k = 2; k <= 21; k++) begin
            @(negedge clk);
            checks++;
            if (k <= 20 && irq !== 1'b0) begin errors++; $display("FAIL irq_busy cycle %0d got %b want 0", k, irq); end
            if (k == 21 && irq !== 1'b1) begin errors++; $display("FAIL irq_after_stop got %b want 1", irq); end
        end
        bus_write(UART_REG_CTRL, 32'h0, 4'h1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] v;
        logic        saw_low;
        bus_write(UART_REG_DIV, 32'd4, 4'hF);
        bus_write(UART_REG_TXDATA, 32'h00, 4'h1);
        bus_write(UART_REG_TXDATA, 32'h00, 4'h1);
        repeat (10) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL mid_data_txd got %b want 0", txd); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL async_reset_txd got %b want 1", txd); end
        @(negedge clk);
        reset = 1'b1;
        bus_read(UART_REG_STATUS, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL post_reset_status got %h want 00000002", v); end
        bus_read(UART_REG_DIV, v);
        checks++;
        if (v !== 32'd868) begin errors++; $display("FAIL post_reset_div got %0d want 868", v); end
        saw_low = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low) begin errors++; $display("FAIL post_reset_no_frame got txd low want txd high"); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_div_regs();
        test_irq();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
